// File: rtl/counter_datachk.sv
// counter_datachk: receive-side checker for the 8-bit incrementing counter
// pattern on the HPIO loopback link.
//
// The checker tries the 8 bit rotations of the received word one at a time
// and locks onto the rotation that makes the stream count up by one.
// While locked, it counts the received words and the words that break the
// pattern.
//
// Handshake: data_valid is a one-way strobe from the RX FIFO read side.
// data_in is consumed on every clk_200m edge where data_valid is high.
// There is no backpressure, so the checker is always ready.
// On a cycle with data_valid low, no checker state changes.
// The one exception is clear, which zeroes the counters in any cycle.
//
// FSM visibility: the two-state FSM is visible directly on the locked
// output, because locked is the state register itself.
module counter_datachk #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic        clk_200m,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        clear,
  output logic        locked,
  output logic [2:0]  rot,
  output logic [7:0]  expected,
  output logic [31:0] word_count,
  output logic [31:0] err_count,
  output logic        err_flag
);

  localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  prev;
  logic        have_prev;
  logic [7:0]  match_cnt;
  logic [7:0]  bad_run;
  logic [15:0] doubled;
  logic [7:0]  aligned;

  // Rotate data_in right by rot: aligned[i] = data_in[(i+rot) mod 8].
  always_comb begin
    doubled = {data_in, data_in};
    aligned = doubled[rot +: 8];
  end

  assign locked = (state == LOCKED);

  // Main checker: rotation search, lock tracking, and the saturating counters.
  always_ff @(posedge clk_200m or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      rot        <= 3'd0;
      prev       <= 8'd0;
      have_prev  <= 1'b0;
      match_cnt  <= 8'd0;
      bad_run    <= 8'd0;
      expected   <= 8'd0;
      word_count <= 32'd0;
      err_count  <= 32'd0;
      err_flag   <= 1'b0;
    end else begin
      err_flag <= 1'b0;

      // clear takes priority over any increment later in this block.
      if (clear) begin
        word_count <= 32'd0;
        err_count  <= 32'd0;
      end

      if (data_valid) begin
        case (state)
          SEARCH: begin
            if (!have_prev) begin
              // First word at this rotation only seeds the comparison.
              prev      <= aligned;
              have_prev <= 1'b1;
              match_cnt <= 8'd0;
            end else if (aligned == prev + 8'd1) begin
              prev <= aligned;
              if (match_cnt + 8'd1 == LOCK_N) begin
                state     <= LOCKED;
                expected  <= aligned + 8'd1;
                bad_run   <= 8'd0;
                match_cnt <= 8'd0;
                have_prev <= 1'b0;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              // Wrong rotation: try the next one and drop this word.
              rot       <= rot + 3'd1;
              have_prev <= 1'b0;
              match_cnt <= 8'd0;
            end
          end

          LOCKED: begin
            if (!clear && word_count != 32'hFFFF_FFFF)
              word_count <= word_count + 32'd1;

            // Always advance, so one corrupted word costs exactly one error.
            expected <= expected + 8'd1;

            if (aligned == expected) begin
              bad_run <= 8'd0;
            end else begin
              err_flag <= 1'b1;
              if (!clear && err_count != 32'hFFFF_FFFF)
                err_count <= err_count + 32'd1;
              if (bad_run + 8'd1 == UNLOCK_N) begin
                // Too many mismatches in a row: search again from the kept rot.
                state     <= SEARCH;
                have_prev <= 1'b0;
                match_cnt <= 8'd0;
                bad_run   <= 8'd0;
              end else begin
                bad_run <= bad_run + 8'd1;
              end
            end
          end

          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: doc/counter_datachk.md
# counter_datachk

Receive-side checker for the 8-bit incrementing counter pattern sent over the HPIO loopback link. It takes the parallel word the RX datapath delivers in the clk_200m domain and searches the 8 possible bit rotations to find the one that makes the stream increment. Once aligned it locks, then counts received words and pattern errors. It sits after the RX FIFO read port, in the top-level loopback test, and is the far end of the counter data generator.

## Interface
Parameters:
- LOCK_COUNT, default 16: number of consecutive +1 steps required to declare lock (legal range 2..255).
- UNLOCK_COUNT, default 4: number of consecutive mismatches while locked that drop lock (legal range 1..255).

Ports:
- clk_200m  in  1  system clock; all logic runs on this clock.
- rst  in  1  reset, asynchronous, active-high.
- data_valid  in  1  data_in holds a new received word this cycle.
- data_in  in  8  raw received word from the RX FIFO.
- clear  in  1  synchronous clear of word_count and err_count; the lock state is not affected.
- locked  out  1  high while in LOCKED.
- rot  out  3  current rotation under test, or the locked rotation.
- expected  out  8  next aligned value expected while LOCKED.
- word_count  out  32  valid words checked while LOCKED; saturates at 0xFFFFFFFF.
- err_count  out  32  mismatching words while LOCKED; saturates at 0xFFFFFFFF.
- err_flag  out  1  one-cycle pulse, registered, for each mismatching word.

## Operation
- Alignment: aligned[i] = data_in[(i+rot) mod 8], which is a rotate-right of data_in by rot. All comparisons use aligned, modulo-256 arithmetic.
- State SEARCH, entered at reset:
  - On the first valid word after entry or after a rotation change, store prev = aligned, set have_prev = 1 and match_cnt = 0.
  - On a later valid word where aligned == prev+1: increment match_cnt and set prev = aligned.
  - On a later valid word that does not match: set rot = rot+1 (wrapping 7 to 0), have_prev = 0 and match_cnt = 0. That word is discarded.
  - When a match brings match_cnt to LOCK_COUNT, go to LOCKED, set expected = aligned+1 and bad_run = 0.
- State LOCKED, on each valid word:
  - If clear is low, word_count increments (saturating).
  - If aligned == expected, set bad_run = 0.
  - If aligned != expected: err_count increments (saturating, unless clear is high), err_flag pulses, and bad_run increments.
  - expected always advances by 1 (expected = expected+1), so one corrupted word costs exactly one error.
  - When bad_run reaches UNLOCK_COUNT, go to SEARCH. rot is kept, have_prev = 0, match_cnt = 0, and that mismatch is still counted.
- Cycles with data_valid low leave all state unchanged, and err_flag is 0.
- clear and a counted word in the same cycle: clear wins, and both counters read 0 next cycle. err_flag still pulses on a mismatch.
- Asynchronous rst mid-operation: immediate return to SEARCH with all outputs at their reset values.

## Timing
- Reset values: locked 0, rot 0, expected 0x00, word_count 0, err_count 0, err_flag 0. Internal: have_prev 0, match_cnt 0, bad_run 0.
- All outputs are registered, with 1-cycle latency. A word valid at edge N updates its outputs after edge N; err_flag is high for the cycle following edge N only.
- Lock latency at the correct rotation with continuous valid: LOCK_COUNT+1 words. locked rises the cycle after the (LOCK_COUNT+1)-th word.
- A wrong rotation costs at least 2 valid words before rot advances. The worst-case search is 7 wrong rotations plus the lock sequence.
- Unlock: locked falls the cycle after the UNLOCK_COUNT-th consecutive mismatch.

## Test plan
- Continuous valid, data_in = 0x00,0x01,... at rot 0, defaults → locked rises after word 17 (0x10), rot = 0. After 100 further words: word_count = 100, err_count = 0.
- data_in = rotate-left-by-3 of the counter → rot settles at 3 and locked = 1. A later 50 words give err_count = 0.
- While locked, replace one word 0x42 with 0xFF → err_count = 1, a single one-cycle err_flag pulse, locked stays 1, and the following 0x43 matches.
- While locked, corrupt 4 consecutive words → err_count = 4, locked falls the cycle after the 4th bad word. A clean stream then relocks after 17 words with rot unchanged.
- Random data_valid gaps (about 50% duty) with a clean stream → locks, err_count = 0, and word_count equals the number of valid words after lock.
- Assert clear on the same cycle as a valid word while locked → word_count = 0 and err_count = 0 next cycle. Then pulse rst asynchronously → all outputs return to reset values immediately, and relock occurs after LOCK_COUNT+1 words.
